// File: rtl/ldpc_decoder_pkg.sv
// Shared defaults and types for the QC-LDPC decoder datapath.
package ldpc_decoder_pkg;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_Z_MAX      = 384;
  localparam int DEF_SHIFT_BITS = 9;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_TAG_DEPTH  = 16;

  typedef logic [DEF_DATA_WIDTH-1:0] msg_vec_t [DEF_Z_MAX-1:0];

  typedef struct packed {
    logic [DEF_SHIFT_BITS-1:0] shift;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } shift_tag_t;

endpackage

// File: rtl/shift_tag_fifo.sv
// Synchronous FIFO of shift/address tags, one per forward-rotated block.
module shift_tag_fifo
  import ldpc_decoder_pkg::*;
#(
  parameter int DEPTH = DEF_TAG_DEPTH
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  shift_tag_t               push_tag,
  input  logic                     pop,
  output shift_tag_t               pop_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  shift_tag_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push && (count_q != FULL) && !flush;
  assign do_pop  = pop && (count_q != '0) && !flush;
  assign pop_tag = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag;
  end

endmodule

// File: rtl/cyclic_unshift_writeback.sv
// Write-back aligner: undoes each block's forward cyclic shift in two
// elastic stages (coarse 16-lane steps, then fine) before the memory write.
module cyclic_unshift_writeback
  import ldpc_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int Z_MAX      = DEF_Z_MAX,
  parameter int SHIFT_BITS = DEF_SHIFT_BITS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TAG_DEPTH  = DEF_TAG_DEPTH
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [SHIFT_BITS-1:0]       z_size,
  input  logic                        tag_valid,
  output logic                        tag_ready,
  input  logic [SHIFT_BITS-1:0]       tag_shift,
  input  logic [ADDR_WIDTH-1:0]       tag_addr,
  input  logic                        msg_valid,
  output logic                        msg_ready,
  input  logic [DATA_WIDTH-1:0]       msg_data [Z_MAX-1:0],
  output logic                        wr_en,
  input  logic                        wr_ready,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [DATA_WIDTH-1:0]       wr_data [Z_MAX-1:0],
  output logic [$clog2(TAG_DEPTH):0]  tag_count,
  output logic                        cfg_err
);

  localparam int LW = $clog2(Z_MAX);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  shift_tag_t            push_tag, head_tag;
  logic                  push, accept, out_load, s1_adv;
  logic [SHIFT_BITS-1:0] z_eff, s_eff, s_coarse;
  logic [DATA_WIDTH-1:0] rot_c [Z_MAX-1:0];
  logic [DATA_WIDTH-1:0] rot_f [Z_MAX-1:0];

  logic                  s1_v_q, s1_v_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [3:0]            s1_sf_q, s1_sf_d;
  logic [DATA_WIDTH-1:0] s1_data_q [Z_MAX-1:0];
  logic [DATA_WIDTH-1:0] s1_data_d [Z_MAX-1:0];
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q [Z_MAX-1:0];
  logic [DATA_WIDTH-1:0] wr_data_d [Z_MAX-1:0];

  // Source lane of output lane i for an inverse shift s in a Z-lane ring.
  function automatic logic [LW-1:0] src_idx(
    input logic [SHIFT_BITS-1:0] i,
    input logic [SHIFT_BITS-1:0] s,
    input logic [SHIFT_BITS-1:0] z
  );
    logic [SHIFT_BITS:0] t;
    if (i >= s) t = {1'b0, i} - {1'b0, s};
    else        t = {1'b0, i} + {1'b0, z} - {1'b0, s};
    return LW'(t);
  endfunction

  assign cfg_err   = (z_size == '0) || (z_size > SHIFT_BITS'(Z_MAX));
  assign tag_ready = (tag_count < CW'(TAG_DEPTH)) && !flush;
  assign out_load  = !wr_en_q || wr_ready;
  assign s1_adv    = !s1_v_q || out_load;
  assign msg_ready = (tag_count != '0) && !cfg_err && !flush && s1_adv;
  assign accept    = msg_valid && msg_ready;
  assign push      = tag_valid && tag_ready;
  assign push_tag  = {tag_shift, tag_addr};

  assign z_eff    = cfg_err ? SHIFT_BITS'(1) : z_size;
  assign s_eff    = head_tag.shift % z_eff;
  assign s_coarse = {s_eff[SHIFT_BITS-1:4], 4'b0000};

  shift_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push),
    .push_tag (push_tag),
    .pop      (accept),
    .pop_tag  (head_tag),
    .count    (tag_count)
  );

  always_comb begin
    for (int i = 0; i < Z_MAX; i++) begin
      rot_c[i] = '0;
      rot_f[i] = '0;
      if (SHIFT_BITS'(i) < z_size) begin
        rot_c[i] = msg_data[src_idx(SHIFT_BITS'(i), s_coarse, z_size)];
        rot_f[i] = s1_data_q[src_idx(SHIFT_BITS'(i),
                                     SHIFT_BITS'(s1_sf_q), z_size)];
      end
    end
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_addr_d = s1_addr_q;
    s1_sf_d   = s1_sf_q;
    s1_data_d = s1_data_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (s1_adv) begin
      s1_v_d = accept;
      if (accept) begin
        s1_addr_d = head_tag.addr;
        s1_sf_d   = s_eff[3:0];
        s1_data_d = rot_c;
      end
    end
    if (out_load) begin
      wr_en_d = s1_v_q;
      if (s1_v_q) begin
        wr_addr_d = s1_addr_q;
        wr_data_d = rot_f;
      end
    end
    if (flush) begin
      s1_v_d  = 1'b0;
      wr_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_addr_q <= '0;
      s1_sf_q   <= '0;
      s1_data_q <= '{default: '0};
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '{default: '0};
    end else begin
      s1_v_q    <= s1_v_d;
      s1_addr_q <= s1_addr_d;
      s1_sf_q   <= s1_sf_d;
      s1_data_q <= s1_data_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
